// File: rtl/iir_pkg.sv
// Shared definitions for the time-shared cascaded-biquad IIR engine.
//
// Contents:
//   state_t           engine sequencer states (IDLE, MAC, WB, OUT)
//   K_B0..K_A2        coefficient slot within a section (address = s*5 + k)
//   N_COEF_PER_SECT   number of coefficients per biquad section
//   DEF_FRAC          default number of coefficient fractional bits (Q2.14)
//   unity_coef()      pass-through coefficient value (1.0) for a given FRAC
//
// Optional feature macro used by the design: IIR_SATURATE_EN.
package iir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        WB   = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam logic [2:0] K_B0 = 3'd0;
    localparam logic [2:0] K_B1 = 3'd1;
    localparam logic [2:0] K_B2 = 3'd2;
    localparam logic [2:0] K_A1 = 3'd3;
    localparam logic [2:0] K_A2 = 3'd4;

    localparam int N_COEF_PER_SECT = 5;
    localparam int DEF_FRAC        = 14;

    // 1.0 in the coefficient fixed-point format; b0 resets to this value.
    function automatic int unity_coef(input int frac);
        return 1 << frac;
    endfunction

endpackage

// File: rtl/iir_cascade_engine_if.sv
// Sample/coefficient bus of the IIR cascade engine.
//
// Signals:
//   xin, in_ch, in_valid / in_ready   sample input handshake
//   clear_state                       zero all filter state (honoured when idle)
//   coef_we, coef_addr, coef_data     coefficient write port (index s*5+k)
//   yout, out_ch, out_valid           filtered sample, one-cycle valid pulse
//
// Modports: master = sample source / controller, slave = the engine.
interface iir_cascade_engine_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int N_SECT = 4,
    parameter int N_CH   = 2
);
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int ADDR_W = $clog2(5 * N_SECT);

    logic signed [DATA_W-1:0] xin;
    logic        [CH_W-1:0]   in_ch;
    logic                     in_valid;
    logic                     in_ready;
    logic                     clear_state;
    logic                     coef_we;
    logic        [ADDR_W-1:0] coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic signed [DATA_W-1:0] yout;
    logic        [CH_W-1:0]   out_ch;
    logic                     out_valid;

    modport master (
        output xin, in_ch, in_valid, clear_state, coef_we, coef_addr, coef_data,
        input  in_ready, yout, out_ch, out_valid
    );

    modport slave (
        input  xin, in_ch, in_valid, clear_state, coef_we, coef_addr, coef_data,
        output in_ready, yout, out_ch, out_valid
    );

endinterface

// File: rtl/iir_mac.sv
// Multiply-accumulate datapath shared by all sections and channels.
//
// Ports:
//   clk30x, rst   clock and asynchronous active-low reset
//   clear         zero the accumulator (start of a section)
//   en            accumulate one product this cycle
//   sub           subtract the product instead of adding (feedback terms)
//   coef, data    multiplier operands
//   y             rounded, scaled section result taken from the accumulator
//
// IIR_SATURATE_EN defined: y is clamped to the DATA_W range; otherwise it wraps.
module iir_mac #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int FRAC   = 14,
    parameter int ACC_W  = DATA_W + COEF_W + 4
) (
    input  logic                     clk30x,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     en,
    input  logic                     sub,
    input  logic signed [COEF_W-1:0] coef,
    input  logic signed [DATA_W-1:0] data,
    output logic signed [DATA_W-1:0] y
);
    localparam int PROD_W = COEF_W + DATA_W;
    localparam logic signed [ACC_W-1:0] HALF_LSB = {{(ACC_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  rounded;

    assign prod     = coef * data;
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = sub ? (acc_q - prod_ext) : (acc_q + prod_ext);
        end
    end

    always_ff @(posedge clk30x or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Round half up, then drop the fractional bits with an arithmetic shift.
    assign rounded = acc_q + HALF_LSB;

`ifdef IIR_SATURATE_EN
    localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = rounded >>> FRAC;
        if (shifted > Y_MAX) begin
            y = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (shifted < Y_MIN) begin
            y = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            y = shifted[DATA_W-1:0];
        end
    end
`else
    assign y = DATA_W'(rounded >>> FRAC);
`endif

endmodule

// File: rtl/iir_cascade_engine.sv
// Time-shared cascaded direct-form-I biquad IIR engine.
//
// One MAC walks N_SECT sections per accepted sample: 5 MAC cycles plus one
// write-back cycle per section, then one OUT cycle that loads the registered
// outputs (out_valid appears 6*N_SECT+1 cycles after the accept edge).
//
// Ports:
//   clk30x   clock, rising edge
//   rst      asynchronous active-low reset
//   bus      iir_cascade_engine_if.slave (sample in/out, clear, coefficient port)
//
// Optional feature macro: IIR_SATURATE_EN (saturate section results in iir_mac).
import iir_pkg::*;

module iir_cascade_engine #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int FRAC   = DEF_FRAC,
    parameter int N_SECT = 4,
    parameter int N_CH   = 2,
    parameter int ACC_W  = DATA_W + COEF_W + 4
) (
    input  logic                  clk30x,
    input  logic                  rst,
    iir_cascade_engine_if.slave   bus
);
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int SECT_W = (N_SECT > 1) ? $clog2(N_SECT) : 1;
    localparam int N_COEF = N_COEF_PER_SECT * N_SECT;
    localparam int ADDR_W = $clog2(N_COEF);
    localparam logic [ADDR_W-1:0]     N_COEF_A  = ADDR_W'(N_COEF);
    localparam logic [SECT_W-1:0]     LAST_SECT = SECT_W'(N_SECT - 1);
    localparam logic signed [COEF_W-1:0] UNITY  = COEF_W'(unity_coef(FRAC));

    state_t                   state_q, state_d;
    logic        [2:0]        k_q, k_d;
    logic        [SECT_W-1:0] s_q, s_d;
    logic        [CH_W-1:0]   ch_q, ch_d;
    logic signed [DATA_W-1:0] x_q, x_d;
    logic                     idle_q, idle_d;
    logic signed [DATA_W-1:0] yout_q, yout_d;
    logic        [CH_W-1:0]   out_ch_q, out_ch_d;
    logic                     out_valid_q, out_valid_d;

    logic signed [COEF_W-1:0] coef_q [N_COEF];
    logic signed [COEF_W-1:0] coef_d [N_COEF];
    logic signed [DATA_W-1:0] x1_q [N_CH][N_SECT];
    logic signed [DATA_W-1:0] x1_d [N_CH][N_SECT];
    logic signed [DATA_W-1:0] x2_q [N_CH][N_SECT];
    logic signed [DATA_W-1:0] x2_d [N_CH][N_SECT];
    logic signed [DATA_W-1:0] y1_q [N_CH][N_SECT];
    logic signed [DATA_W-1:0] y1_d [N_CH][N_SECT];
    logic signed [DATA_W-1:0] y2_q [N_CH][N_SECT];
    logic signed [DATA_W-1:0] y2_d [N_CH][N_SECT];

    logic                     mac_clear, mac_en, mac_sub;
    logic signed [COEF_W-1:0] mac_coef;
    logic signed [DATA_W-1:0] mac_data;
    logic signed [DATA_W-1:0] y_wb;
    logic        [ADDR_W-1:0] cidx;
    logic        [CH_W-1:0]   in_ch_ok;
    logic                     accept;

    // Out-of-range channel numbers fall back to channel 0; only needed when
    // the channel field can encode more values than there are channels.
    if ((1 << CH_W) > N_CH) begin : g_ch_clip
        assign in_ch_ok = (bus.in_ch < CH_W'(N_CH)) ? bus.in_ch : '0;
    end else begin : g_ch_pass
        assign in_ch_ok = bus.in_ch;
    end

    // clear_state wins over a sample offered in the same idle cycle.
    assign bus.in_ready  = idle_q & ~bus.clear_state;
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.yout      = yout_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;

    // Operand select for the current tap; feedback taps are subtracted.
    assign cidx     = ADDR_W'(N_COEF_PER_SECT * int'(s_q) + int'(k_q));
    assign mac_coef = coef_q[cidx];

    always_comb begin
        mac_sub  = 1'b0;
        mac_data = x_q;
        case (k_q)
            K_B1:    mac_data = x1_q[ch_q][s_q];
            K_B2:    mac_data = x2_q[ch_q][s_q];
            K_A1: begin
                mac_data = y1_q[ch_q][s_q];
                mac_sub  = 1'b1;
            end
            K_A2: begin
                mac_data = y2_q[ch_q][s_q];
                mac_sub  = 1'b1;
            end
            default: mac_data = x_q;
        endcase
    end

    iir_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .FRAC   (FRAC),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk30x (clk30x),
        .rst    (rst),
        .clear  (mac_clear),
        .en     (mac_en),
        .sub    (mac_sub),
        .coef   (mac_coef),
        .data   (mac_data),
        .y      (y_wb)
    );

    // Sequencer: x_q carries the current section input and, after the last
    // write-back, the final result that OUT copies to yout.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        s_d         = s_q;
        ch_d        = ch_q;
        x_d         = x_q;
        idle_d      = idle_q;
        yout_d      = yout_q;
        out_ch_d    = out_ch_q;
        out_valid_d = 1'b0;
        coef_d      = coef_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        y1_d        = y1_q;
        y2_d        = y2_q;
        mac_clear   = 1'b0;
        mac_en      = 1'b0;

        // Coefficients only change between samples.
        if (idle_q && bus.coef_we && (bus.coef_addr < N_COEF_A)) begin
            coef_d[bus.coef_addr] = bus.coef_data;
        end

        case (state_q)
            IDLE: begin
                if (bus.clear_state) begin
                    for (int c = 0; c < N_CH; c++) begin
                        for (int s = 0; s < N_SECT; s++) begin
                            x1_d[c][s] = '0;
                            x2_d[c][s] = '0;
                            y1_d[c][s] = '0;
                            y2_d[c][s] = '0;
                        end
                    end
                end else if (accept) begin
                    x_d       = bus.xin;
                    ch_d      = in_ch_ok;
                    s_d       = '0;
                    k_d       = K_B0;
                    mac_clear = 1'b1;
                    idle_d    = 1'b0;
                    state_d   = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (k_q == K_A2) begin
                    k_d     = K_B0;
                    state_d = WB;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            WB: begin
                x2_d[ch_q][s_q] = x1_q[ch_q][s_q];
                x1_d[ch_q][s_q] = x_q;
                y2_d[ch_q][s_q] = y1_q[ch_q][s_q];
                y1_d[ch_q][s_q] = y_wb;
                x_d             = y_wb;
                mac_clear       = 1'b1;
                if (s_q == LAST_SECT) begin
                    state_d = OUT;
                end else begin
                    s_d     = s_q + 1'b1;
                    state_d = MAC;
                end
            end
            OUT: begin
                yout_d      = x_q;
                out_ch_d    = ch_q;
                out_valid_d = 1'b1;
                idle_d      = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset aborts any sample in flight and restores pass-through coefficients.
    always_ff @(posedge clk30x or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            s_q         <= '0;
            ch_q        <= '0;
            x_q         <= '0;
            idle_q      <= 1'b1;
            yout_q      <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < N_COEF; i++) begin
                coef_q[i] <= ((i % N_COEF_PER_SECT) == int'(K_B0)) ? UNITY : '0;
            end
            for (int c = 0; c < N_CH; c++) begin
                for (int s = 0; s < N_SECT; s++) begin
                    x1_q[c][s] <= '0;
                    x2_q[c][s] <= '0;
                    y1_q[c][s] <= '0;
                    y2_q[c][s] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            s_q         <= s_d;
            ch_q        <= ch_d;
            x_q         <= x_d;
            idle_q      <= idle_d;
            yout_q      <= yout_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            coef_q      <= coef_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            y1_q        <= y1_d;
            y2_q        <= y2_d;
        end
    end

endmodule

// File: tb/tb_iir_cascade_engine.sv
// Self-checking bench for iir_cascade_engine with a behavioural filter model.
// Honours IIR_SATURATE_EN the same way the design does.
module tb_iir_cascade_engine;

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int FRAC   = 14;
    localparam int N_SECT = 4;
    localparam int N_CH   = 2;
    localparam int N_COEF = 5 * N_SECT;
    localparam int LAT    = 6 * N_SECT + 1;

    logic clk30x = 1'b0;
    logic rst    = 1'b0;

    iir_cascade_engine_if #(
        .DATA_W (DATA_W), .COEF_W (COEF_W), .N_SECT (N_SECT), .N_CH (N_CH)
    ) bus ();

    iir_cascade_engine #(
        .DATA_W (DATA_W), .COEF_W (COEF_W), .FRAC (FRAC),
        .N_SECT (N_SECT), .N_CH (N_CH)
    ) dut (
        .clk30x (clk30x),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk30x = ~clk30x;

    int checks = 0;
    int passes = 0;

    // Reference model: coefficient table and per-channel/per-section history.
    longint m_coef [N_COEF];
    longint m_x1 [N_CH][N_SECT];
    longint m_x2 [N_CH][N_SECT];
    longint m_y1 [N_CH][N_SECT];
    longint m_y2 [N_CH][N_SECT];

    function automatic longint sext16(input longint v);
        longint r;
        r = v & 64'hFFFF;
        if (r >= 32768) r = r - 65536;
        return r;
    endfunction

    function automatic longint model_result(input longint acc);
        longint r;
        r = (acc + (longint'(1) << (FRAC - 1))) >>> FRAC;
`ifdef IIR_SATURATE_EN
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
`else
        return sext16(r);
`endif
    endfunction

    function automatic void model_clear();
        for (int c = 0; c < N_CH; c++) begin
            for (int s = 0; s < N_SECT; s++) begin
                m_x1[c][s] = 0; m_x2[c][s] = 0; m_y1[c][s] = 0; m_y2[c][s] = 0;
            end
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N_COEF; i++) m_coef[i] = ((i % 5) == 0) ? (longint'(1) << FRAC) : 0;
        model_clear();
    endfunction

    function automatic void model_write(input int addr, input longint data);
        if (addr < N_COEF) m_coef[addr] = sext16(data);
    endfunction

    function automatic longint model_run(input int ch_in, input longint x_in);
        longint x, acc, y;
        int ch;
        ch = (ch_in < N_CH) ? ch_in : 0;
        x  = sext16(x_in);
        for (int s = 0; s < N_SECT; s++) begin
            acc = m_coef[5*s] * x + m_coef[5*s+1] * m_x1[ch][s] + m_coef[5*s+2] * m_x2[ch][s]
                - m_coef[5*s+3] * m_y1[ch][s] - m_coef[5*s+4] * m_y2[ch][s];
            y = model_result(acc);
            m_x2[ch][s] = m_x1[ch][s];
            m_x1[ch][s] = x;
            m_y2[ch][s] = m_y1[ch][s];
            m_y1[ch][s] = y;
            x = y;
        end
        return x;
    endfunction

    // Drivers (no checking inside).
    task automatic write_coef(input int addr, input longint data);
        @(negedge clk30x);
        bus.coef_we   = 1'b1;
        bus.coef_addr = 5'(addr);
        bus.coef_data = 16'(data);
        @(posedge clk30x);
        #1;
        bus.coef_we = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk30x);
        bus.clear_state = 1'b1;
        @(posedge clk30x);
        #1;
        bus.clear_state = 1'b0;
    endtask

    task automatic run_sample(input int ch, input longint x,
                              output longint y, output int och, output int lat);
        @(negedge clk30x);
        bus.in_valid = 1'b1;
        bus.xin      = 16'(x);
        bus.in_ch    = 1'(ch);
        @(posedge clk30x);
        #1;
        bus.in_valid = 1'b0;
        lat = -1;
        y   = 0;
        och = -1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk30x);
            #1;
            if (bus.out_valid === 1'b1) begin
                lat = c;
                y   = longint'(bus.yout);
                och = int'(bus.out_ch);
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.xin = '0; bus.in_ch = '0; bus.in_valid = 1'b0; bus.clear_state = 1'b0;
        bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk30x);
        @(negedge clk30x);
        checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready); else passes++;
        checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid); else passes++;
        checks++; if (bus.yout !== 16'sd0) $display("[TB] FAIL reset_yout: got %h want 0000", bus.yout); else passes++;
        checks++; if (bus.out_ch !== 1'b0) $display("[TB] FAIL reset_out_ch: got %0d want 0", bus.out_ch); else passes++;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_passthrough();
        longint y, exp_y;
        int och, lat;
        exp_y = model_run(0, 'h1234);
        run_sample(0, 'h1234, y, och, lat);
        checks++; if (lat != LAT) $display("[TB] FAIL pass_latency: got %0d want %0d", lat, LAT); else passes++;
        checks++; if (y != exp_y) $display("[TB] FAIL pass_yout: got %0d want %0d", y, exp_y); else passes++;
        checks++; if (och != 0) $display("[TB] FAIL pass_out_ch: got %0d want 0", och); else passes++;
    endtask

    task automatic test_gain();
        longint y, exp_y;
        int och, lat;
        longint xs [2] = '{1000, -1000};
        write_coef(0, 'h2000); model_write(0, 'h2000);
        foreach (xs[i]) begin
            exp_y = model_run(0, xs[i]);
            run_sample(0, xs[i], y, och, lat);
            checks++; if (y != exp_y || lat != LAT) $display("[TB] FAIL gain_x%0d: got %0d (lat %0d) want %0d", xs[i], y, lat, exp_y); else passes++;
        end
    endtask

    task automatic test_impulse();
        longint y, exp_y;
        int och, lat;
        write_coef(0, 'h4000); model_write(0, 'h4000);
        write_coef(3, 'hE000); model_write(3, 'hE000);
        pulse_clear(); model_clear();
        for (int n = 0; n < 5; n++) begin
            exp_y = model_run(0, (n == 0) ? 1000 : 0);
            run_sample(0, (n == 0) ? 1000 : 0, y, och, lat);
            checks++; if (y != exp_y) $display("[TB] FAIL impulse_n%0d: got %0d want %0d", n, y, exp_y); else passes++;
        end
    endtask

    task automatic test_channels();
        longint y, exp_y;
        int och, lat;
        int     chs [4] = '{0, 1, 0, 1};
        longint xs  [4] = '{1000, 200, 0, 0};
        pulse_clear(); model_clear();
        for (int i = 0; i < 4; i++) begin
            exp_y = model_run(chs[i], xs[i]);
            run_sample(chs[i], xs[i], y, och, lat);
            checks++; if (y != exp_y || och != chs[i]) $display("[TB] FAIL chan_step%0d: got %0d ch%0d want %0d ch%0d", i, y, och, exp_y, chs[i]); else passes++;
        end
    endtask

    task automatic test_clear_with_valid();
        longint y, exp_y;
        int och, lat, seen;
        exp_y = model_run(0, 1000);
        run_sample(0, 1000, y, och, lat);
        @(negedge clk30x);
        bus.clear_state = 1'b1; bus.in_valid = 1'b1; bus.xin = 16'sd77; bus.in_ch = 1'b0;
        bus.coef_we = 1'b1; bus.coef_addr = 5'd5; bus.coef_data = 16'h2000;
        #1;
        checks++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL clear_blocks_ready: got %b want 0", bus.in_ready); else passes++;
        @(posedge clk30x);
        #1;
        bus.clear_state = 1'b0; bus.in_valid = 1'b0; bus.coef_we = 1'b0;
        model_clear(); model_write(5, 'h2000);
        seen = 0;
        repeat (LAT + 5) begin
            @(posedge clk30x); #1;
            if (bus.out_valid === 1'b1) seen = 1;
        end
        checks++; if (seen != 0) $display("[TB] FAIL clear_no_output: got %0d want 0", seen); else passes++;
        exp_y = model_run(0, 1000);
        run_sample(0, 1000, y, och, lat);
        checks++; if (y != exp_y) $display("[TB] FAIL clear_then_sample: got %0d want %0d", y, exp_y); else passes++;
    endtask

    task automatic test_saturate();
        longint y, exp_y;
        int och, lat;
        write_coef(3, 0);        model_write(3, 0);
        write_coef(5, 'h4000);   model_write(5, 'h4000);
        write_coef(0, 'h7FFF);   model_write(0, 'h7FFF);
        pulse_clear(); model_clear();
        exp_y = model_run(0, 'h7FFF);
        run_sample(0, 'h7FFF, y, och, lat);
        checks++; if (y != exp_y) $display("[TB] FAIL saturate_or_wrap: got %0d want %0d", y, exp_y); else passes++;
    endtask

    task automatic test_busy_coef();
        longint y, exp_y;
        int och, lat;
        exp_y = model_run(1, 100);
        @(negedge clk30x);
        bus.in_valid = 1'b1; bus.xin = 16'sd100; bus.in_ch = 1'b1;
        @(posedge clk30x); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk30x);
        @(negedge clk30x);
        bus.coef_we = 1'b1; bus.coef_addr = 5'd0; bus.coef_data = 16'h1000;
        @(posedge clk30x); #1;
        bus.coef_we = 1'b0;
        lat = -1; y = 0;
        for (int c = 5; c <= 100; c++) begin
            @(posedge clk30x); #1;
            if (bus.out_valid === 1'b1) begin lat = c; y = longint'(bus.yout); break; end
        end
        checks++; if (y != exp_y || lat != LAT) $display("[TB] FAIL busy_coef_first: got %0d (lat %0d) want %0d", y, lat, exp_y); else passes++;
        exp_y = model_run(1, 100);
        run_sample(1, 100, y, och, lat);
        checks++; if (y != exp_y) $display("[TB] FAIL busy_coef_ignored: got %0d want %0d", y, exp_y); else passes++;
    endtask

    task automatic test_reset_mid();
        longint y, exp_y;
        int och, lat, seen;
        @(negedge clk30x);
        bus.in_valid = 1'b1; bus.xin = 16'sh0200; bus.in_ch = 1'b0;
        @(posedge clk30x); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk30x);
        #1;
        rst = 1'b0;
        seen = 0;
        repeat (2) begin @(posedge clk30x); #1; if (bus.out_valid === 1'b1) seen = 1; end
        @(negedge clk30x);
        rst = 1'b1;
        repeat (LAT + 5) begin @(posedge clk30x); #1; if (bus.out_valid === 1'b1) seen = 1; end
        model_reset();
        checks++; if (seen != 0) $display("[TB] FAIL reset_mid_no_output: got %0d want 0", seen); else passes++;
        checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL reset_mid_ready: got %b want 1", bus.in_ready); else passes++;
        exp_y = model_run(0, 'h0100);
        run_sample(0, 'h0100, y, och, lat);
        checks++; if (y != exp_y || lat != LAT) $display("[TB] FAIL reset_mid_passthrough: got %0d (lat %0d) want %0d", y, lat, exp_y); else passes++;
    endtask

    task automatic test_random();
        longint y, exp_y, x, cval;
        int och, lat, ch, bad_addr;
        for (int a = 0; a < N_COEF; a++) begin
            if ((a % 5) < 3) cval = longint'($urandom_range(16383)) - 8192;
            else             cval = longint'($urandom_range(8191)) - 4096;
            write_coef(a, cval); model_write(a, cval);
        end
        bad_addr = N_COEF + int'($urandom_range(31 - N_COEF));
        write_coef(bad_addr, 'h5555); model_write(bad_addr, 'h5555);
        pulse_clear(); model_clear();
        for (int n = 0; n < 20; n++) begin
            ch = int'($urandom_range(N_CH - 1));
            x  = longint'($urandom_range(65535)) - 32768;
            exp_y = model_run(ch, x);
            run_sample(ch, x, y, och, lat);
            checks++; if (y != exp_y || och != ch || lat != LAT) $display("[TB] FAIL random_%0d: got %0d ch%0d lat%0d want %0d ch%0d lat%0d", n, y, och, lat, exp_y, ch, LAT); else passes++;
            checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL back_to_back_ready_%0d: got %b want 1", n, bus.in_ready); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_gain();
        test_impulse();
        test_channels();
        test_clear_with_valid();
        test_saturate();
        test_busy_coef();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
